voice_bank: RTL

Parametrised N-channel voice generator: the next generation of the hand-wired kick/snare/pulse track. Each channel has a phase accumulator, a selectable waveform (pulse, triangle, saw, noise) and a decaying volume envelope, all loaded through a valid/ready trigger port. Channels are mixed through one time-multiplexed adder with saturation, and the mix drives the existing first-order sigma-delta 1-bit output. A sequencer (song ROM or CPU) sits upstream and issues triggers. The output pin feeds the audio PWM filter.

---
 rtl/voice_bank.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/voice_bank.sv
// N-voice tone generator: per-channel phase accumulator, waveform and decaying envelope,
// a time-multiplexed saturating mixer and a first-order sigma-delta 1-bit output.
module voice_bank #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned INC_W      = 10,
  parameter int unsigned VOL_W      = 4,
  parameter int unsigned SAMPLE_DIV = 1024,
  localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk48,
  input  logic                 rst,
  input  logic                 trig_valid,
  output logic                 trig_ready,
  input  logic [CH_W-1:0]      trig_ch,
  input  logic [1:0]           trig_wave,
  input  logic [INC_W-1:0]     trig_inc,
  input  logic [3:0]           trig_decay,
  input  logic                 tick,
  output logic                 sample_strobe,
  output logic [15:0]          audio_sample,
  output logic [NCH*VOL_W-1:0] vol_out,
  output logic                 out
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [VOL_W-1:0] MUTE = '1;

  logic [DIV_W-1:0]   div;
  logic [15:0]        phase   [NCH];
  logic [INC_W-1:0]   inc     [NCH];
  logic [1:0]         wave    [NCH];
  logic [3:0]         decay   [NCH];
  logic [3:0]         env_cnt [NCH];
  logic [VOL_W-1:0]   vol     [NCH];
  logic [14:0]        lfsr;
  logic signed [18:0] mix;
  logic [15:0]        sd_acc;

  logic               in_scan;
  logic               last_div;
  logic               trig_fire;
  logic [15:0]        cur_phase;
  logic [1:0]         cur_wave;
  logic [VOL_W-1:0]   cur_vol;
  logic signed [15:0] wv;
  logic signed [15:0] wv_att;
  logic signed [18:0] contrib;
  logic [15:0]        sat;
  logic [16:0]        sd_sum;

  assign in_scan    = div < DIV_W'(NCH);
  assign last_div   = div == DIV_W'(SAMPLE_DIV - 1);
  assign trig_ready = !in_scan;
  assign trig_fire  = trig_valid && trig_ready;

  function automatic logic signed [15:0] wave_fn(input logic [1:0] w, input logic [15:0] p,
                                                 input logic [12:0] nz);
    logic signed [15:0] t;
    case (w)
      2'd0: t = p[15] ? -16'sd8192 : 16'sd8192;
      2'd1: t = ($signed(p ^ {16{p[15]}}) - 16'sd16384) >>> 1;
      2'd2: t = $signed(p - 16'h8000) >>> 2;
      default: t = $signed({3'b000, nz}) - 16'sd4096;
    endcase
    return t;
  endfunction

  // Select the channel being scanned this cycle
  always_comb begin
    cur_phase = '0;
    cur_wave  = '0;
    cur_vol   = MUTE;
    for (int i = 0; i < NCH; i++) begin
      if (div == DIV_W'(i)) begin
        cur_phase = phase[i];
        cur_wave  = wave[i];
        cur_vol   = vol[i];
      end
    end
  end

  always_comb begin
    wv      = wave_fn(cur_wave, cur_phase, lfsr[12:0]);
    wv_att  = wv >>> cur_vol;
    contrib = (cur_vol == MUTE) ? '0 : {{3{wv_att[15]}}, wv_att};
  end

  always_comb begin
    if (mix > 19'sd32767)       sat = 16'h7FFF;
    else if (mix < -19'sd32768) sat = 16'h8000;
    else                        sat = mix[15:0];
  end

  always_comb begin
    vol_out = '0;
    for (int i = 0; i < NCH; i++) vol_out[i*VOL_W +: VOL_W] = vol[i];
  end

  // Divider, mixer, noise source and per-channel state
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      div           <= '0;
      mix           <= '0;
      lfsr          <= 15'h1CAF;
      audio_sample  <= 16'h8000;
      sample_strobe <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        phase[i]   <= '0;
        inc[i]     <= '0;
        wave[i]    <= '0;
        decay[i]   <= '0;
        env_cnt[i] <= '0;
        vol[i]     <= MUTE;
      end
    end else begin
      div           <= last_div ? '0 : div + DIV_W'(1);
      sample_strobe <= 1'b0;
      if (in_scan) mix <= (div == '0) ? contrib : mix + contrib;
      if (div == DIV_W'(NCH)) begin
        audio_sample  <= sat ^ 16'h8000;
        sample_strobe <= 1'b1;
        lfsr          <= {lfsr[0], lfsr[0] ^ lfsr[14], lfsr[13:1]};
      end
      for (int i = 0; i < NCH; i++) begin
        if (in_scan && div == DIV_W'(i)) phase[i] <= phase[i] + 16'(inc[i]);
        // A trigger wins over a coincident envelope tick on its own channel
        if (trig_fire && trig_ch == CH_W'(i)) begin
          wave[i]    <= trig_wave;
          inc[i]     <= trig_inc;
          decay[i]   <= trig_decay;
          phase[i]   <= '0;
          vol[i]     <= '0;
          env_cnt[i] <= '0;
        end else if (tick && decay[i] != 4'd0) begin
          if (env_cnt[i] + 4'd1 == decay[i]) begin
            env_cnt[i] <= '0;
            vol[i]     <= (vol[i] == MUTE) ? MUTE : vol[i] + VOL_W'(1);
          end else begin
            env_cnt[i] <= env_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  assign sd_sum = {1'b0, sd_acc} + {1'b0, audio_sample};

  // First-order sigma-delta: carry out of the accumulator is the bitstream
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      sd_acc <= '0;
      out    <= 1'b0;
    end else begin
      sd_acc <= sd_sum[15:0];
      out    <= sd_sum[16];
    end
  end

endmodule
